// File: rtl/buzzer_scheduler.sv
// Shares the clock's single piezo between alarm, hourly chime and key-click with
// fixed priority and per-source beep sequencing. Optional snooze: define BUZZ_SNOOZE_EN.
module buzzer_scheduler #(
    parameter int ALARM_ON_MS    = 300,
    parameter int ALARM_OFF_MS   = 200,
    parameter int ALARM_BEEPS    = 3,
    parameter int ALARM_PAUSE_MS = 1000,
    parameter int ALARM_GROUPS   = 4,
    parameter int CHIME_ON_MS    = 100,
    parameter int CHIME_OFF_MS   = 100,
    parameter int CHIME_BEEPS    = 2,
    parameter int KEY_MS         = 30,
    parameter int CNT_W          = 11
`ifdef BUZZ_SNOOZE_EN
    ,
    parameter int SNOOZE_MS      = 300000
`endif
) (
    input  logic       clk_1kHz,
    input  logic       rst,
    input  logic       req_alarm,
    input  logic       req_chime,
    input  logic       req_key,
    input  logic       stop,
    output logic       buzzer,
    output logic       busy,
    output logic [1:0] active_src
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TONE  = 2'd1,
        GAP   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_KEY   = 2'd1;
    localparam logic [1:0] SRC_CHIME = 2'd2;
    localparam logic [1:0] SRC_ALARM = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] ALARM_ON_L    = CNT_W'(ALARM_ON_MS);
    localparam logic [CNT_W-1:0] ALARM_OFF_L   = CNT_W'(ALARM_OFF_MS);
    localparam logic [CNT_W-1:0] ALARM_PAUSE_L = CNT_W'(ALARM_PAUSE_MS);
    localparam logic [CNT_W-1:0] CHIME_ON_L    = CNT_W'(CHIME_ON_MS);
    localparam logic [CNT_W-1:0] CHIME_OFF_L   = CNT_W'(CHIME_OFF_MS);
    localparam logic [CNT_W-1:0] KEY_L         = CNT_W'(KEY_MS);
    localparam logic [7:0]       ALARM_BEEPS_L  = 8'(ALARM_BEEPS);
    localparam logic [7:0]       CHIME_BEEPS_L  = 8'(CHIME_BEEPS);
    localparam logic [7:0]       ALARM_GROUPS_L = 8'(ALARM_GROUPS);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] phase_len;
    logic [7:0]       beep;
    logic [7:0]       group;
    logic             pend_alarm;
    logic             pend_chime;
    logic             pend_key;
    logic             phase_end;
    logic             last_beep;
    logic             pattern_done;
    logic             stop_alarm;
    logic             alarm_go;
    logic             take_chime;
    logic             take_key;
    logic             snooze_fire;

    // Length of the phase currently being timed, chosen by phase and owner.
    always_comb begin
        phase_len = KEY_L;
        case (state)
            TONE: begin
                case (active_src)
                    SRC_ALARM: phase_len = ALARM_ON_L;
                    SRC_CHIME: phase_len = CHIME_ON_L;
                    default:   phase_len = KEY_L;
                endcase
            end
            GAP:     phase_len = (active_src == SRC_ALARM) ? ALARM_OFF_L : CHIME_OFF_L;
            PAUSE:   phase_len = ALARM_PAUSE_L;
            default: phase_len = KEY_L;
        endcase
    end

    assign phase_end = (cnt == phase_len);
    assign last_beep = ((beep + 8'd1) ==
                        ((active_src == SRC_ALARM) ? ALARM_BEEPS_L : CHIME_BEEPS_L));

    // True on the final cycle of a pattern; a same-source request then is a new event.
    assign pattern_done = phase_end &&
                          (((state == TONE) && (active_src == SRC_KEY)) ||
                           ((state == TONE) && (active_src == SRC_CHIME) && last_beep) ||
                           ((state == PAUSE) && ((group + 8'd1) == ALARM_GROUPS_L)));

    assign stop_alarm = stop && (active_src == SRC_ALARM);
    assign alarm_go   = pend_alarm && !stop && (active_src != SRC_ALARM);
    assign take_chime = (state == IDLE) && !alarm_go && pend_chime;
    assign take_key   = (state == IDLE) && !alarm_go && !pend_chime && pend_key;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk_1kHz) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= CNT_ONE;
            beep       <= 8'd0;
            group      <= 8'd0;
            buzzer     <= 1'b0;
            active_src <= SRC_NONE;
            pend_alarm <= 1'b0;
            pend_chime <= 1'b0;
            pend_key   <= 1'b0;
        end else begin
            pend_alarm <= (alarm_go || stop_alarm) ? 1'b0 :
                          (pend_alarm | snooze_fire |
                           (req_alarm && ((active_src != SRC_ALARM) || pattern_done)));
            pend_chime <= take_chime ? 1'b0 :
                          (pend_chime |
                           (req_chime && ((active_src != SRC_CHIME) || pattern_done)));
            pend_key   <= take_key ? 1'b0 :
                          (pend_key |
                           (req_key && ((active_src != SRC_KEY) || pattern_done)));

            if (stop_alarm) begin
                state      <= IDLE;
                active_src <= SRC_NONE;
                buzzer     <= 1'b0;
                cnt        <= CNT_ONE;
                beep       <= 8'd0;
                group      <= 8'd0;
            end else if (alarm_go) begin
                // Alarm starts from idle or aborts a chime/key; the aborted one is dropped.
                state      <= TONE;
                active_src <= SRC_ALARM;
                buzzer     <= 1'b1;
                cnt        <= CNT_ONE;
                beep       <= 8'd0;
                group      <= 8'd0;
            end else begin
                case (state)
                    IDLE: begin
                        buzzer <= 1'b0;
                        cnt    <= CNT_ONE;
                        beep   <= 8'd0;
                        group  <= 8'd0;
                        if (take_chime) begin
                            state      <= TONE;
                            active_src <= SRC_CHIME;
                            buzzer     <= 1'b1;
                        end else if (take_key) begin
                            state      <= TONE;
                            active_src <= SRC_KEY;
                            buzzer     <= 1'b1;
                        end
                    end
                    TONE: begin
                        if (!phase_end) begin
                            cnt    <= cnt + 1'b1;
                            buzzer <= ~buzzer;
                        end else begin
                            cnt    <= CNT_ONE;
                            buzzer <= 1'b0;
                            if (active_src == SRC_KEY) begin
                                state      <= IDLE;
                                active_src <= SRC_NONE;
                            end else begin
                                beep <= beep + 8'd1;
                                if (!last_beep) begin
                                    state <= GAP;
                                end else if (active_src == SRC_ALARM) begin
                                    state <= PAUSE;
                                end else begin
                                    state      <= IDLE;
                                    active_src <= SRC_NONE;
                                end
                            end
                        end
                    end
                    GAP: begin
                        if (phase_end) begin
                            cnt    <= CNT_ONE;
                            state  <= TONE;
                            buzzer <= 1'b1;
                        end else begin
                            cnt    <= cnt + 1'b1;
                            buzzer <= 1'b0;
                        end
                    end
                    PAUSE: begin
                        buzzer <= 1'b0;
                        if (phase_end) begin
                            cnt  <= CNT_ONE;
                            beep <= 8'd0;
                            if ((group + 8'd1) == ALARM_GROUPS_L) begin
                                state      <= IDLE;
                                active_src <= SRC_NONE;
                                group      <= 8'd0;
                            end else begin
                                group  <= group + 8'd1;
                                state  <= TONE;
                                buzzer <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        active_src <= SRC_NONE;
                        buzzer     <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef BUZZ_SNOOZE_EN
    localparam logic [18:0] SNOOZE_L     = 19'(SNOOZE_MS - 1);
    localparam logic [10:0] REPLAY_GRACE = 11'd1000;

    logic        snooze_armed;
    logic        replaying;
    logic        stop_q;
    logic        snooze_fire_q;
    logic [18:0] snooze_cnt;
    logic [10:0] replay_age;

    // A stop held over from the silencing press must not count as a second press.
    always_ff @(posedge clk_1kHz) begin
        if (rst) begin
            snooze_armed  <= 1'b0;
            replaying     <= 1'b0;
            stop_q        <= 1'b0;
            snooze_fire_q <= 1'b0;
            snooze_cnt    <= 19'd0;
            replay_age    <= 11'd0;
        end else begin
            stop_q        <= stop;
            snooze_fire_q <= 1'b0;
            if (req_alarm && (active_src != SRC_ALARM)) begin
                snooze_armed <= 1'b0;
                replaying    <= 1'b0;
            end else if (stop_alarm) begin
                replaying <= 1'b0;
                if (replaying && (replay_age < REPLAY_GRACE)) begin
                    snooze_armed <= 1'b0;
                end else begin
                    snooze_armed <= 1'b1;
                    snooze_cnt   <= SNOOZE_L;
                end
            end else if (snooze_armed) begin
                if (stop && !stop_q) begin
                    snooze_armed <= 1'b0;
                end else if (snooze_cnt == 19'd0) begin
                    snooze_armed  <= 1'b0;
                    snooze_fire_q <= 1'b1;
                    replaying     <= 1'b1;
                    replay_age    <= 11'd0;
                end else begin
                    snooze_cnt <= snooze_cnt - 19'd1;
                end
            end else if (replaying && (active_src == SRC_ALARM) &&
                         (replay_age < REPLAY_GRACE)) begin
                replay_age <= replay_age + 11'd1;
            end
        end
    end

    assign snooze_fire = snooze_fire_q;
`else
    assign snooze_fire = 1'b0;
`endif

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Self-checking bench for buzzer_scheduler: a pattern-timeline model checked every
// cycle, plus literal expectations for the key, chime and alarm scenarios.
module tb_buzzer_scheduler;

    logic       clk_1kHz = 1'b0;
    logic       rst = 1'b1;
    logic       req_alarm = 1'b0;
    logic       req_chime = 1'b0;
    logic       req_key = 1'b0;
    logic       stop = 1'b0;
    logic       buzzer;
    logic       busy;
    logic [1:0] active_src;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    always #5 clk_1kHz = ~clk_1kHz;

    buzzer_scheduler dut (
        .clk_1kHz  (clk_1kHz),
        .rst       (rst),
        .req_alarm (req_alarm),
        .req_chime (req_chime),
        .req_key   (req_key),
        .stop      (stop),
        .buzzer    (buzzer),
        .busy      (busy),
        .active_src(active_src)
    );

    // Model: which source owns the piezo and how far into its pattern it is.
    int m_src = 0;
    int m_t = 0;
    bit m_pa = 1'b0;
    bit m_pc = 1'b0;
    bit m_pk = 1'b0;

    function automatic int pat_len(int src);
        case (src)
            1:       return 30;
            2:       return 2 * (100 + 100) - 100;
            3:       return 4 * (3 * 300 + 2 * 200 + 1000);
            default: return 0;
        endcase
    endfunction

    function automatic logic exp_buzz(int src, int t);
        int off;
        bit tone;
        off = 0;
        tone = 1'b0;
        case (src)
            1: begin
                off = t;
                tone = (t < 30);
            end
            2: begin
                off = t % 200;
                tone = (t < 300) && (off < 100);
            end
            3: begin
                off = (t % 2300) % 500;
                tone = ((t % 2300) < 1300) && (off < 300);
            end
            default: tone = 1'b0;
        endcase
        return tone && ((off % 2) == 0);
    endfunction

    always @(posedge clk_1kHz) begin : model
        bit ending, stop_al, alarm_go, take_c, take_k, n_pa, n_pc, n_pk;
        if (rst) begin
            m_src = 0;
            m_t = 0;
            m_pa = 1'b0;
            m_pc = 1'b0;
            m_pk = 1'b0;
        end else begin
            ending   = (m_src != 0) && (m_t == pat_len(m_src) - 1);
            stop_al  = stop && (m_src == 3);
            alarm_go = m_pa && !stop && (m_src != 3);
            take_c   = (m_src == 0) && !alarm_go && m_pc;
            take_k   = (m_src == 0) && !alarm_go && !m_pc && m_pk;
            n_pa = (alarm_go || stop_al) ? 1'b0 : (m_pa || (req_alarm && ((m_src != 3) || ending)));
            n_pc = take_c ? 1'b0 : (m_pc || (req_chime && ((m_src != 2) || ending)));
            n_pk = take_k ? 1'b0 : (m_pk || (req_key && ((m_src != 1) || ending)));
            if (stop_al) begin
                m_src = 0;
                m_t = 0;
            end else if (alarm_go) begin
                m_src = 3;
                m_t = 0;
            end else if (m_src == 0) begin
                if (take_c) m_src = 2;
                else if (take_k) m_src = 1;
                m_t = 0;
            end else if (ending) begin
                m_src = 0;
                m_t = 0;
            end else begin
                m_t = m_t + 1;
            end
            m_pa = n_pa;
            m_pc = n_pc;
            m_pk = n_pk;
        end
    end

    always @(negedge clk_1kHz) begin : compare
        logic [3:0] exp_v;
        if (check_en) begin
            exp_v = {exp_buzz(m_src, m_t), (m_src != 0), 2'(m_src)};
            checks++;
            if ({buzzer, busy, active_src} !== exp_v) begin
                errors++;
                $display("[TB] FAIL cycle_model t=%0t got buz=%b busy=%b src=%0d want buz=%b busy=%b src=%0d",
                         $time, buzzer, busy, active_src, exp_v[3], exp_v[2], exp_v[1:0]);
            end
        end
    end

    task automatic applyStimulus(input logic a, input logic c, input logic k);
        @(negedge clk_1kHz);
        req_alarm = a;
        req_chime = c;
        req_key   = k;
        @(negedge clk_1kHz);
        req_alarm = 1'b0;
        req_chime = 1'b0;
        req_key   = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic eb, input logic ebusy,
                               input logic [1:0] esrc);
        checks++;
        if ({buzzer, busy, active_src} !== {eb, ebusy, esrc}) begin
            errors++;
            $display("[TB] FAIL %s got buz=%b busy=%b src=%0d want buz=%b busy=%b src=%0d",
                     name, buzzer, busy, active_src, eb, ebusy, esrc);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic measureBusy(output int cycles, output int rises);
        logic prev;
        cycles = 0;
        rises = 0;
        prev = 1'b0;
        while ((busy === 1'b1) && (cycles < 12000)) begin
            cycles++;
            if (buzzer && !prev) rises++;
            prev = buzzer;
            @(negedge clk_1kHz);
        end
        if (cycles >= 12000) begin
            checks++;
            errors++;
            $display("[TB] FAIL busy_timeout got %0d cycles want under 12000", cycles);
        end
    endtask

    initial begin
        int cyc, rises;
        rst = 1'b1;
        repeat (3) @(negedge clk_1kHz);
        check_en = 1'b1;
        checkOutput("reset_state", 1'b0, 1'b0, 2'd0);
        rst = 1'b0;

        $display("[TB] key click");
        applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge clk_1kHz);
        checkOutput("key_first_tone", 1'b1, 1'b1, 2'd1);
        measureBusy(cyc, rises);
        checkCount("key_busy", cyc, 30);
        checkCount("key_rises", rises, 15);
        checkOutput("key_done", 1'b0, 1'b0, 2'd0);

        $display("[TB] hourly chime");
        applyStimulus(1'b0, 1'b1, 1'b0);
        @(negedge clk_1kHz);
        checkOutput("chime_first_tone", 1'b1, 1'b1, 2'd2);
        measureBusy(cyc, rises);
        checkCount("chime_busy", cyc, 300);
        checkCount("chime_rises", rises, 100);

        $display("[TB] full alarm");
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk_1kHz);
        checkOutput("alarm_first_tone", 1'b1, 1'b1, 2'd3);
        measureBusy(cyc, rises);
        checkCount("alarm_busy", cyc, 9200);
        checkCount("alarm_rises", rises, 1800);

        $display("[TB] alarm preempts chime");
        applyStimulus(1'b0, 1'b1, 1'b0);
        @(negedge clk_1kHz);
        repeat (49) @(negedge clk_1kHz);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("preempt_still_chime", 1'b0, 1'b1, 2'd2);
        @(negedge clk_1kHz);
        checkOutput("preempt_alarm", 1'b1, 1'b1, 2'd3);
        measureBusy(cyc, rises);
        checkCount("preempt_alarm_busy", cyc, 9200);
        repeat (10) @(negedge clk_1kHz);
        checkOutput("chime_not_replayed", 1'b0, 1'b0, 2'd0);

        $display("[TB] alarm and chime together, stop mid-alarm");
        applyStimulus(1'b1, 1'b1, 1'b0);
        @(negedge clk_1kHz);
        checkOutput("alarm_wins", 1'b1, 1'b1, 2'd3);
        repeat (700) @(negedge clk_1kHz);
        checkOutput("alarm_cycle_700", 1'b1, 1'b1, 2'd3);
        stop = 1'b1;
        @(negedge clk_1kHz);
        stop = 1'b0;
        checkOutput("stop_silences", 1'b0, 1'b0, 2'd0);
        @(negedge clk_1kHz);
        checkOutput("chime_after_stop", 1'b1, 1'b1, 2'd2);
        measureBusy(cyc, rises);
        checkCount("chime_after_stop_busy", cyc, 300);

        $display("[TB] stop held blocks a new alarm");
        @(negedge clk_1kHz);
        stop = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge clk_1kHz);
        checkOutput("stop_blocks_alarm", 1'b0, 1'b0, 2'd0);
        stop = 1'b0;
        @(negedge clk_1kHz);
        checkOutput("alarm_after_release", 1'b1, 1'b1, 2'd3);
        stop = 1'b1;
        @(negedge clk_1kHz);
        stop = 1'b0;
        checkOutput("stop_cancels", 1'b0, 1'b0, 2'd0);
        repeat (5) @(negedge clk_1kHz);

        $display("[TB] chime waits behind key, repeated key absorbed");
        applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge clk_1kHz);
        repeat (3) @(negedge clk_1kHz);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("chime_waits", 1'b0, 1'b1, 2'd1);
        measureBusy(cyc, rises);
        checkCount("key_rest_busy", cyc, 25);
        checkOutput("idle_between", 1'b0, 1'b0, 2'd0);
        @(negedge clk_1kHz);
        checkOutput("chime_after_key", 1'b1, 1'b1, 2'd2);
        measureBusy(cyc, rises);
        checkCount("chime_after_key_busy", cyc, 300);
        repeat (5) @(negedge clk_1kHz);
        checkOutput("key_not_replayed", 1'b0, 1'b0, 2'd0);

        $display("[TB] reset during alarm tone");
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk_1kHz);
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (8) @(negedge clk_1kHz);
        rst = 1'b1;
        @(negedge clk_1kHz);
        checkOutput("reset_mid_alarm", 1'b0, 1'b0, 2'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk_1kHz);
        checkOutput("reset_cleared_pending", 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge clk_1kHz);
        checkOutput("key_after_reset", 1'b1, 1'b1, 2'd1);
        measureBusy(cyc, rises);
        checkCount("key_after_reset_busy", cyc, 30);

        repeat (3) @(negedge clk_1kHz);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/buzzer_scheduler.md
Name: buzzer_scheduler

Overview:
- Owns the single piezo output of the digital clock and shares it between three requesters: alarm, hourly chime and key-click.
- Arbitrates by fixed priority and sequences each requester's beep pattern (tone / gap / group pause).
- Drives `buzzer` as a 500 Hz square wave (toggle every clk_1kHz cycle) during tone phases.
- Sits between the timekeeping/alarm-compare logic and the buzzer pin.

Parameters:
- ALARM_ON_MS, 300, alarm tone length in cycles (1 cycle = 1 ms)
- ALARM_OFF_MS, 200, silence between alarm beeps
- ALARM_BEEPS, 3, beeps per alarm group
- ALARM_PAUSE_MS, 1000, silence after each alarm group
- ALARM_GROUPS, 4, groups per alarm event
- CHIME_ON_MS, 100, chime tone length
- CHIME_OFF_MS, 100, silence between chime beeps
- CHIME_BEEPS, 2, beeps per chime
- KEY_MS, 30, key-click tone length
- CNT_W, 11, phase counter width; must hold max(ON, OFF, PAUSE) + 1

Ports:
- clk_1kHz  input  1  system clock, 1 kHz
- rst  input  1  synchronous, active-high reset
- req_alarm  input  1  one-cycle pulse: alarm time reached
- req_chime  input  1  one-cycle pulse: top of hour
- req_key  input  1  one-cycle pulse: key pressed
- stop  input  1  level; cancels the running alarm
- buzzer  output  1  piezo drive
- busy  output  1  high whenever the FSM is not IDLE
- active_src  output  2  0 = none, 1 = key, 2 = chime, 3 = alarm

Behaviour:
- Reset (sync, rst = 1 at posedge):
  - state = IDLE; buzzer = 0; busy = 0; active_src = 0.
  - All pending flags, counters, beep and group counts are cleared.
  - rst overrides every other input in the same cycle.
  - Reset mid-pattern silences `buzzer` on the next edge.
- Pending flags:
  - A req_* pulse sets pend_* at the next edge.
  - A repeated pulse while pending or while that source is active is absorbed; no queue depth.
- Arbitration in IDLE, priority alarm > chime > key:
  - Winner's pend flag is cleared and its source is loaded.
  - Transition to TONE on the edge after the pend flag is seen; latency from req pulse to first buzzer toggle is 2 cycles.
- Preemption:
  - pend_alarm set while a chime or key pattern is active aborts that pattern on the next edge and starts the alarm at TONE, beep 0, group 0.
  - The aborted chime or key is dropped, not resumed.
  - A chime request during a key click waits; it does not preempt.
- FSM states: IDLE, TONE, GAP, PAUSE. The counter cnt counts 1..N; a phase ends when cnt == N, then cnt reloads to 1.
  - TONE: buzzer toggles every cycle.
    - At end of TONE, key → IDLE.
    - At end of TONE, other sources: beep += 1; if beep == BEEPS then (alarm → PAUSE, chime → IDLE), else → GAP.
  - GAP: buzzer = 0; at end → TONE.
  - PAUSE (alarm only): buzzer = 0. At end: group += 1; if group == ALARM_GROUPS → IDLE, else beep = 0 → TONE.
- Leaving TONE forces buzzer = 0 on that same edge; buzzer never idles high.
- stop:
  - stop = 1 while active_src == 3 → IDLE on the next edge and pend_alarm is cleared.
  - stop has no effect on chime or key.
  - A stop held high also blocks a new alarm from starting; pend_alarm is still set and waits.
- Simultaneous events:
  - Alarm and chime requests in the same cycle: alarm wins, chime stays pending and plays after the alarm ends or is stopped.
  - A request in the same cycle as pattern end is pended normally; IDLE lasts at least 1 cycle between patterns.
- Outputs:
  - busy = (state != IDLE).
  - active_src is registered and equals 0 in IDLE.

Optional Feature:
- Macro: BUZZ_SNOOZE_EN.
- When defined:
  - Adds parameter SNOOZE_MS (default 300000) and a 19-bit snooze counter.
  - stop during an alarm enters IDLE and arms the snooze counter.
  - When the counter expires, pend_alarm is set again and the full alarm pattern replays.
  - A second stop within the first 1000 cycles of any replay, or at any time during the snooze interval, cancels the alarm permanently.
  - A fresh req_alarm clears snooze.
- When undefined: stop simply cancels the alarm; no snooze logic is synthesized.

Test Plan:
- req_key pulse at t0 → buzzer toggles t0+2..t0+31 (30 cycles, 15 rising edges), busy falls at t0+32, active_src = 1 throughout.
- req_chime → 2 × (100 toggling, 100 silent) with no trailing gap, then IDLE; total busy = 300 cycles.
- req_alarm, no stop → 4 groups of 3 × (300 on / 200 off, last off replaced by 1000 pause); busy = 4 × (3×300 + 2×200 + 1000) = 9200 cycles.
- Chime running, req_alarm at chime cycle 50 → active_src switches 2 → 3 next edge, chime not replayed after alarm.
- req_alarm and req_chime in the same cycle, stop asserted at alarm cycle 700 → buzzer 0 next edge, then chime pattern starts within 2 cycles.
- rst asserted during alarm TONE → next edge buzzer = 0, busy = 0, all pending cleared; a subsequent req_key plays normally.
